// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared constants, bus layouts and FSM states for the write-back stage
package wb_stage_pkg;

    // Exception vector: bit 0 is ERTN, bits above are cause flags
    localparam int EXC_ERTN_BIT = 0;

    // CSR numbers the write-back stage cares about
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_TLBIDX = 14'h010;
    localparam logic [13:0] CSR_TLBEHI = 14'h011;
    localparam logic [13:0] CSR_ASID   = 14'h018;
    localparam logic [13:0] CSR_DMW0   = 14'h180;
    localparam logic [13:0] CSR_DMW1   = 14'h181;

    // ms_rf_collect = {ld_pend, csr_re, rf_we, waddr[4:0], wdata[31:0]}
    localparam int RF_BUS_W       = 40;
    localparam int RF_WDATA_LSB   = 0;
    localparam int RF_WADDR_LSB   = 32;
    localparam int RF_WE_BIT      = 37;
    localparam int RF_CSR_RE_BIT  = 38;
    localparam int RF_LD_PEND_BIT = 39;
    localparam int WS_RF_W        = 38;

    // ms_csr_collect = {csr_we, csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0]}
    localparam int CSR_BUS_W      = 79;
    localparam int CSR_WVALUE_LSB = 0;
    localparam int CSR_WMASK_LSB  = 32;
    localparam int CSR_NUM_LSB    = 64;
    localparam int CSR_WE_BIT     = 78;

    // TLB op field at the bottom of ms_to_ws_bus: {tlbsrch, tlbrd, tlbwr, tlbfill, invtlb}
    localparam int OP_INVTLB  = 0;
    localparam int OP_TLBFILL = 1;
    localparam int OP_TLBWR   = 2;
    localparam int OP_TLBRD   = 3;
    localparam int OP_TLBSRCH = 4;
    localparam int OP_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TLB_WAIT = 2'd1,
        ST_REFETCH  = 2'd2
    } wb_state_e;

    // CSRs that change translation or privilege; later fetches must be redone
    function automatic logic csr_needs_refetch(input logic [13:0] num);
        return (num == CSR_ASID) || (num == CSR_TLBEHI) || (num == CSR_CRMD) ||
               (num == CSR_DMW0) || (num == CSR_DMW1);
    endfunction

endpackage

// File: rtl/wb_tlb_seq.sv
// rtl/wb_tlb_seq.sv - TLB op commit sequencer: FSM, rand_idx counter and TLB strobes
module wb_tlb_seq
    import wb_stage_pkg::*;
#(
    parameter int TLB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_ws_valid,
    input  logic                 i_except_any,
    input  logic [OP_W-1:0]      i_ops,
    input  logic                 i_s1_found,
    input  logic [TLB_IDX_W-1:0] i_s1_index,
    input  logic [TLB_IDX_W-1:0] i_tlbidx_index,
    input  logic                 i_csr_refetch,
    input  logic [31:0]          i_ws_pc,
    output logic                 o_ws_live,
    output logic                 o_wb_ex,
    output logic                 o_ws_ready_go,
    output logic                 o_refetch_flush,
    output logic [31:0]          o_refetch_pc,
    output logic                 o_tlb_we,
    output logic [TLB_IDX_W-1:0] o_tlb_w_index,
    output logic                 o_tlbsrch_we,
    output logic                 o_tlbsrch_hit,
    output logic [TLB_IDX_W-1:0] o_tlbsrch_index,
    output logic                 o_tlbrd_en,
    output logic                 o_invtlb_en
);

    wb_state_e            r_state;
    logic                 r_refetch_flush;
    logic [31:0]          r_refetch_pc;
    logic [TLB_IDX_W-1:0] r_rand_idx;

    logic w_ws_live;
    logic w_wb_ex;
    logic w_retire_ok;
    logic w_tlb_go;
    logic w_csr_go;
    logic w_srch;
    logic w_rd;
    logic w_wr;
    logic w_fill;
    logic w_inv;

    // The instruction sitting in WB while REFETCH is active was fetched on the stale path
    assign w_ws_live   = i_ws_valid & (r_state != ST_REFETCH);
    assign w_wb_ex     = w_ws_live & i_except_any;
    assign w_retire_ok = w_ws_live & ~w_wb_ex & (r_state == ST_IDLE);
    assign w_tlb_go    = w_retire_ok & (|i_ops);
    assign w_csr_go    = w_retire_ok & i_csr_refetch & ~(|i_ops);

    // Fixed priority decode so exactly one strobe fires even on a malformed vector
    assign w_srch = w_tlb_go & i_ops[OP_TLBSRCH];
    assign w_rd   = w_tlb_go & ~i_ops[OP_TLBSRCH] & i_ops[OP_TLBRD];
    assign w_wr   = w_tlb_go & ~i_ops[OP_TLBSRCH] & ~i_ops[OP_TLBRD] & i_ops[OP_TLBWR];
    assign w_fill = w_tlb_go & ~i_ops[OP_TLBSRCH] & ~i_ops[OP_TLBRD] & ~i_ops[OP_TLBWR]
                  & i_ops[OP_TLBFILL];
    assign w_inv  = w_tlb_go & ~i_ops[OP_TLBSRCH] & ~i_ops[OP_TLBRD] & ~i_ops[OP_TLBWR]
                  & ~i_ops[OP_TLBFILL] & i_ops[OP_INVTLB];

    assign o_ws_live       = w_ws_live;
    assign o_wb_ex         = w_wb_ex;
    assign o_ws_ready_go   = ~w_tlb_go;
    assign o_refetch_flush = r_refetch_flush;
    assign o_refetch_pc    = r_refetch_pc;
    assign o_tlb_we        = w_wr | w_fill;
    assign o_tlb_w_index   = w_wr ? i_tlbidx_index : r_rand_idx;
    assign o_tlbsrch_we    = w_srch;
    assign o_tlbsrch_hit   = i_s1_found;
    assign o_tlbsrch_index = i_s1_index;
    assign o_tlbrd_en      = w_rd;
    assign o_invtlb_en     = w_inv;

    // Commit sequencer: TLB op stalls one cycle, then a single-cycle refetch flush
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= ST_IDLE;
            r_refetch_flush <= 1'b0;
            r_refetch_pc    <= 32'd0;
        end else begin
            r_refetch_flush <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tlb_go) begin
                        r_state      <= ST_TLB_WAIT;
                        r_refetch_pc <= i_ws_pc + 32'd4;
                    end else if (w_csr_go) begin
                        r_state         <= ST_REFETCH;
                        r_refetch_flush <= 1'b1;
                        r_refetch_pc    <= i_ws_pc + 32'd4;
                    end
                end
                ST_TLB_WAIT: begin
                    if (w_wb_ex) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state         <= ST_REFETCH;
                        r_refetch_flush <= 1'b1;
                    end
                end
                ST_REFETCH: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Free-running victim index for TLBFILL
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rand_idx <= '0;
        end else begin
            r_rand_idx <= r_rand_idx + 1'b1;
        end
    end

    a_tlb_op_onehot: assert property (@(posedge clk) disable iff (!resetn)
        i_ws_valid |-> $onehot0(i_ops));

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage top; optional debug trace ports under WB_DEBUG_TRACE_EN
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int TLB_IDX_W = 4,
    parameter int EXC_W     = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    output logic                              ws_allowin,
    input  logic                              ms_to_ws_valid,
    input  logic [31:0]                       ms_pc,
    input  logic [RF_BUS_W-1:0]               ms_rf_collect,
    input  logic [EXC_W+1+TLB_IDX_W+OP_W-1:0] ms_to_ws_bus,
    input  logic [CSR_BUS_W-1:0]              ms_csr_collect,
    output logic                              rf_we,
    output logic [4:0]                        rf_waddr,
    output logic [31:0]                       rf_wdata,
    output logic [WS_RF_W-1:0]                ws_rf_collect,
    output logic                              csr_we,
    output logic [13:0]                       csr_num,
    output logic [31:0]                       csr_wmask,
    output logic [31:0]                       csr_wvalue,
    output logic                              wb_ex,
    output logic [EXC_W-2:0]                  wb_ecode_vec,
    output logic [31:0]                       wb_pc,
    output logic                              ertn_flush,
    output logic                              except_flush,
    output logic                              refetch_flush,
    output logic [31:0]                       refetch_pc,
    output logic                              tlb_we,
    output logic [TLB_IDX_W-1:0]              tlb_w_index,
    input  logic [TLB_IDX_W-1:0]              tlbidx_index_in,
    output logic                              tlbsrch_we,
    output logic                              tlbsrch_hit,
    output logic [TLB_IDX_W-1:0]              tlbsrch_index,
    output logic                              tlbrd_en,
    output logic                              invtlb_en
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]                       debug_wb_pc,
    output logic [3:0]                        debug_wb_rf_we,
    output logic [4:0]                        debug_wb_rf_wnum,
    output logic [31:0]                       debug_wb_rf_wdata
`endif
);

    localparam int BUS_W     = EXC_W + 1 + TLB_IDX_W + OP_W;
    localparam int IDX_LSB   = OP_W;
    localparam int FOUND_BIT = OP_W + TLB_IDX_W;
    localparam int EXC_LSB   = FOUND_BIT + 1;

    logic                 r_ws_valid;
    logic [31:0]          r_ws_pc;
    logic                 r_rf_we;
    logic [4:0]           r_rf_waddr;
    logic [31:0]          r_rf_wdata;
    logic [BUS_W-1:0]     r_bus;
    logic                 r_csr_we;
    logic [13:0]          r_csr_num;
    logic [31:0]          r_csr_wmask;
    logic [31:0]          r_csr_wvalue;

    logic [EXC_W-1:0]     w_exc;
    logic                 w_ws_live;
    logic                 w_wb_ex;
    logic                 w_ws_ready_go;
    logic                 w_refetch_flush;
    logic                 w_ertn;
    logic                 w_except_flush;
    logic                 w_rf_we;
    logic                 w_csr_refetch;
    logic                 w_unused_ok;

    // Completed loads only reach WB, and csr_re is consumed earlier in the pipe
    assign w_unused_ok = ^{ms_rf_collect[RF_LD_PEND_BIT], ms_rf_collect[RF_CSR_RE_BIT]};

    assign w_exc          = r_bus[EXC_LSB +: EXC_W];
    assign w_ertn         = w_ws_live & w_exc[EXC_ERTN_BIT] & ~w_wb_ex;
    assign w_except_flush = w_wb_ex | w_ertn | w_refetch_flush;
    assign w_rf_we        = w_ws_live & r_rf_we & ~w_wb_ex;
    assign w_csr_refetch  = r_csr_we & csr_needs_refetch(r_csr_num);

    assign ws_allowin    = ~r_ws_valid | w_ws_ready_go;
    assign rf_we         = w_rf_we;
    assign rf_waddr      = r_rf_waddr;
    assign rf_wdata      = r_rf_wdata;
    assign ws_rf_collect = {w_rf_we, r_rf_waddr, r_rf_wdata};
    assign csr_we        = w_ws_live & r_csr_we & ~w_wb_ex;
    assign csr_num       = r_csr_num;
    assign csr_wmask     = r_csr_wmask;
    assign csr_wvalue    = r_csr_wvalue;
    assign wb_ex         = w_wb_ex;
    assign wb_ecode_vec  = w_wb_ex ? w_exc[EXC_W-1:1] : '0;
    assign wb_pc         = r_ws_pc;
    assign ertn_flush    = w_ertn;
    assign except_flush  = w_except_flush;
    assign refetch_flush = w_refetch_flush;

    // WB valid bit: a flush empties the stage and blocks any capture in the same cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ws_valid <= 1'b0;
        end else if (w_except_flush) begin
            r_ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            r_ws_valid <= ms_to_ws_valid;
        end
    end

    // WB payload registers, loaded on every accepted handoff from MEM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ws_pc      <= 32'd0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= 5'd0;
            r_rf_wdata   <= 32'd0;
            r_bus        <= '0;
            r_csr_we     <= 1'b0;
            r_csr_num    <= 14'd0;
            r_csr_wmask  <= 32'd0;
            r_csr_wvalue <= 32'd0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            r_ws_pc      <= ms_pc;
            r_rf_we      <= ms_rf_collect[RF_WE_BIT];
            r_rf_waddr   <= ms_rf_collect[RF_WADDR_LSB +: 5];
            r_rf_wdata   <= ms_rf_collect[RF_WDATA_LSB +: 32];
            r_bus        <= ms_to_ws_bus;
            r_csr_we     <= ms_csr_collect[CSR_WE_BIT];
            r_csr_num    <= ms_csr_collect[CSR_NUM_LSB +: 14];
            r_csr_wmask  <= ms_csr_collect[CSR_WMASK_LSB +: 32];
            r_csr_wvalue <= ms_csr_collect[CSR_WVALUE_LSB +: 32];
        end
    end

    wb_tlb_seq #(
        .TLB_IDX_W (TLB_IDX_W)
    ) u_tlb_seq (
        .clk             (clk),
        .resetn          (resetn),
        .i_ws_valid      (r_ws_valid),
        .i_except_any    (|w_exc[EXC_W-1:1]),
        .i_ops           (r_bus[OP_W-1:0]),
        .i_s1_found      (r_bus[FOUND_BIT]),
        .i_s1_index      (r_bus[IDX_LSB +: TLB_IDX_W]),
        .i_tlbidx_index  (tlbidx_index_in),
        .i_csr_refetch   (w_csr_refetch),
        .i_ws_pc         (r_ws_pc),
        .o_ws_live       (w_ws_live),
        .o_wb_ex         (w_wb_ex),
        .o_ws_ready_go   (w_ws_ready_go),
        .o_refetch_flush (w_refetch_flush),
        .o_refetch_pc    (refetch_pc),
        .o_tlb_we        (tlb_we),
        .o_tlb_w_index   (tlb_w_index),
        .o_tlbsrch_we    (tlbsrch_we),
        .o_tlbsrch_hit   (tlbsrch_hit),
        .o_tlbsrch_index (tlbsrch_index),
        .o_tlbrd_en      (tlbrd_en),
        .o_invtlb_en     (invtlb_en)
    );

`ifdef WB_DEBUG_TRACE_EN
    // Retirement trace for difftest; all sources are reset registers, so zero under reset
    assign debug_wb_pc       = r_ws_pc;
    assign debug_wb_rf_we    = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_rf_waddr;
    assign debug_wb_rf_wdata = r_rf_wdata;
`endif

endmodule
